apb_mem_bridge: RTL and testbench
=================================

Name: apb_mem_bridge

Overview:
- APB slave front-end that sits directly upstream of the single-port memory block.
- Tracks the APB transfer phases, latches address, direction and write data in SETUP, and drives the memory's en/wr_rd/address/write_data interface during ACCESS.
- Returns PREADY/PRDATA/PSLVERR from the memory's data_ready/read_data.
- Adds address decode (range and alignment checks) and a wait-state timeout so a stalled memory cannot hang the bus.

Parameters:
- ADDR_WIDTH, 32, width of paddr and mem_addr
- DATA_WIDTH, 32, width of pwdata/prdata/mem data
- MEM_DEPTH, 64, number of memory words; valid word index 0..MEM_DEPTH-1
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before forced error completion (>=2)

Ports:
- clk  in  1  clock; all logic rising-edge
- reset_n  in  1  synchronous, active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable (ACCESS phase)
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  DATA_WIDTH  write data
- prdata  out  DATA_WIDTH  read data
- pready  out  1  transfer complete
- pslverr  out  1  transfer error, valid when pready=1
- mem_en  out  1  memory enable
- mem_wr_rd  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  word address (paddr>>2, zero-extended)
- mem_wdata  out  DATA_WIDTH  write data to memory
- mem_rdata  in  DATA_WIDTH  memory read_data
- mem_data_ready  in  1  memory data_ready

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; wait counter=0; latched addr/dir/data=0; error flag=0.
  - All outputs deassert: mem_en=0, pready=0, pslverr=0, prdata=0, mem_wr_rd=0, mem_addr=0, mem_wdata=0.
  - Reset asserted mid-ACCESS aborts the transfer; no pready is issued for it.
- State machine (registered): IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when psel=1 and penable=0. psel=1 with penable=1 in IDLE is a protocol violation: ignored, stay IDLE.
  - SETUP: latch paddr, pwrite, pwdata, and decode error = (paddr[1:0]!=0) OR (paddr>>2 >= MEM_DEPTH). Next state = ACCESS unconditionally.
  - ACCESS: stays while pready=0. When pready=1: next = SETUP if psel=1 and penable=0 next cycle; otherwise IDLE.
  - If psel drops during ACCESS before completion: abort to IDLE, mem_en=0.
- Memory drive (combinational from state and latches):
  - mem_en = (state==ACCESS) & psel & penable & !error & !timeout.
  - mem_wr_rd, mem_addr, mem_wdata come from the SETUP latches and are held stable through the whole of ACCESS.
- Completion, combinational, in ACCESS only:
  - error=1: pready=1 and pslverr=1 in the first ACCESS cycle; mem_en never asserted.
  - Write: mem_data_ready is high the same cycle mem_en rises, so pready=1 in the first ACCESS cycle (zero wait states); the memory writes on that edge.
  - Read: the memory asserts data_ready one cycle after en, so pready=1 in the second ACCESS cycle (one wait state); prdata=mem_rdata in that cycle.
  - prdata=0 whenever pready=0, pslverr=1, or the transfer is a write.
- Wait counter:
  - Cleared in SETUP; increments each ACCESS cycle with pready=0; saturates.
  - timeout = (counter == TIMEOUT_CYCLES-1) & !mem_data_ready. When timeout=1: pready=1, pslverr=1, mem_en=0 that cycle.
- mem_data_ready seen outside ACCESS is ignored.
- Back-to-back transfers always have a SETUP cycle between them with mem_en=0. This clears the memory's internal ready flag, so a stale ready cannot complete the next read.

Decomposition:
- Shared package apb_pkg:
  - state enum (IDLE/SETUP/ACCESS)
  - APB_WORD_SHIFT=2 constant
  - address-decode function (aligned/in-range check)
- One natural sub-module: apb_wait_timer, holding the wait counter and timeout compare (clear, enable, TIMEOUT_CYCLES parameter, timeout output).

Test Plan:
- Write paddr=0x10, pwdata=0xDEADBEEF -> first ACCESS cycle: mem_en=1, mem_wr_rd=1, mem_addr=4, mem_wdata=0xDEADBEEF, pready=1, pslverr=0.
- Read paddr=0x10 after the above (bench connected to the real memory) -> ACCESS cycle 1: pready=0; ACCESS cycle 2: pready=1, prdata=0xDEADBEEF, pslverr=0; mem_en low in the following SETUP/IDLE cycle.
- Read paddr=0x100 (word 64) and write paddr=0x02 -> each completes in the first ACCESS cycle with pready=1, pslverr=1, prdata=0; mem_en never 1.
- mem_data_ready tied 0, read paddr=0x0 -> pready=0 for ACCESS cycles 1..15, pready=1 and pslverr=1 in cycle 16, then IDLE.
- Back-to-back write 0x4/0x11111111 then read 0x4 with psel held high -> SETUP between transfers with mem_en=0; read returns 0x11111111 in its second ACCESS cycle.
- reset_n=0 during read ACCESS cycle 1, then psel=1/penable=1 with no SETUP -> next cycle all outputs 0, state IDLE; the no-SETUP enable is ignored (no mem_en, no pready).

Source files
------------

// File: rtl/apb_mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
//   Shared definitions for the APB-to-memory bridge:
//     - apb_state_e    : transfer-phase state encoding (IDLE/SETUP/ACCESS)
//     - APB_WORD_SHIFT : byte-to-word address shift for 32-bit words
//     - apb_addr_ok()  : word-aligned and in-range address check
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_WORD_SHIFT = 2;

  // The address is passed zero-extended to 64 bits so one function serves any
  // bus width up to 64. It returns 1 only for an aligned word inside 0..depth-1.
  function automatic logic apb_addr_ok(input logic [63:0] byte_addr,
                                       input int unsigned depth);
    logic aligned;
    logic in_range;
    aligned  = (byte_addr[1:0] == 2'b00);
    in_range = ((byte_addr >> APB_WORD_SHIFT) < 64'(depth));
    return aligned & in_range;
  endfunction

endpackage

// File: rtl/apb_mem_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_mem_bridge_if
//   Bundles the APB slave signals and the single-port memory signals seen by
//   the bridge.
//   Modports:
//     slave  : the bridge (consumes APB requests, drives the memory)
//     master : the APB requester (drives psel/penable/pwrite/paddr/pwdata)
//     mem    : the memory (consumes en/wr_rd/addr/wdata, returns rdata/ready)
// -----------------------------------------------------------------------------
interface apb_mem_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  // APB side
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  // Memory side
  logic                  mem_en;
  logic                  mem_wr_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_data_ready;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr,
    output mem_en, mem_wr_rd, mem_addr, mem_wdata,
    input  mem_rdata, mem_data_ready
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport mem (
    input  mem_en, mem_wr_rd, mem_addr, mem_wdata,
    output mem_rdata, mem_data_ready
  );

endinterface

// File: rtl/apb_mem_bridge_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
//   Counts ACCESS wait states and flags a timeout when the count reaches
//   TIMEOUT_CYCLES-1 and the memory is still not ready.
//   Ports:
//     clk       : clock, rising edge
//     reset_n   : synchronous active-low reset
//     clear_i   : clear the count (asserted in SETUP)
//     enable_i  : count one wait state (ACCESS cycle without completion)
//     ready_i   : memory data_ready
//     timeout_o : forced-completion request for the current cycle
// -----------------------------------------------------------------------------
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Wait-state counter; saturates at the timeout threshold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  // A ready arriving in the threshold cycle still wins over the timeout.
  assign timeout_o = (cnt_q == CNT_MAX) & ~ready_i;

endmodule

// File: rtl/apb_mem_bridge.sv
// -----------------------------------------------------------------------------
// apb_mem_bridge
//   APB slave front-end for a single-port memory. Latches the request in
//   SETUP, drives the memory during ACCESS and returns pready/prdata/pslverr.
//   Misaligned or out-of-range addresses complete at once with an error, and
//   a wait-state timeout forces an error completion if the memory stalls.
//   Ports:
//     clk      : clock, rising edge
//     reset_n  : synchronous active-low reset
//     bus_if   : apb_mem_bridge_if.slave (APB request/response + memory port)
// -----------------------------------------------------------------------------
module apb_mem_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_DEPTH      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             reset_n,
  apb_mem_bridge_if.slave bus_if
);

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic in_access_s;
  logic bus_active_s;
  logic timeout_raw_s;
  logic timeout_s;
  logic pready_s;
  logic pslverr_s;
  logic mem_en_s;
  logic timer_clear_s;
  logic timer_enable_s;

  assign in_access_s  = (state_q == ACCESS);
  assign bus_active_s = bus_if.psel & bus_if.penable;
  // The counter holds its last value in IDLE, so only trust it in ACCESS.
  assign timeout_s    = in_access_s & timeout_raw_s;

  assign timer_clear_s  = (state_q == SETUP);
  assign timer_enable_s = in_access_s & ~pready_s;

  apb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (timer_clear_s),
    .enable_i  (timer_enable_s),
    .ready_i   (bus_if.mem_data_ready),
    .timeout_o (timeout_raw_s)
  );

  // Completion: decode error first, then timeout, then memory ready.
  always_comb begin
    pready_s  = 1'b0;
    pslverr_s = 1'b0;
    if (in_access_s) begin
      if (err_q) begin
        pready_s  = 1'b1;
        pslverr_s = 1'b1;
      end else if (timeout_s) begin
        pready_s  = 1'b1;
        pslverr_s = 1'b1;
      end else if (bus_active_s && bus_if.mem_data_ready) begin
        pready_s  = 1'b1;
        pslverr_s = 1'b0;
      end else begin
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
      end
    end else begin
      pready_s  = 1'b0;
      pslverr_s = 1'b0;
    end
  end

  assign mem_en_s = in_access_s & bus_active_s & ~err_q & ~timeout_s;

  // Next-state and request-latch logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // psel with penable already high is a protocol violation; ignore it.
        if (bus_if.psel && !bus_if.penable) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        addr_d  = bus_if.paddr;
        wr_d    = bus_if.pwrite;
        wdata_d = bus_if.pwdata;
        err_d   = ~apb_addr_ok(64'(bus_if.paddr), MEM_DEPTH);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_s) begin
          if (bus_if.psel && !bus_if.penable) begin
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if (!bus_if.psel) begin
          // Requester withdrew before completion: abort.
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request latches.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_if.pready    = pready_s;
  assign bus_if.pslverr   = pslverr_s;
  // Read data is only forwarded on a successful read completion.
  assign bus_if.prdata    = (pready_s & ~pslverr_s & ~wr_q) ? bus_if.mem_rdata : '0;
  assign bus_if.mem_en    = mem_en_s;
  assign bus_if.mem_wr_rd = wr_q;
  assign bus_if.mem_addr  = addr_q >> APB_WORD_SHIFT;
  assign bus_if.mem_wdata = wdata_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_bridge
//   Directed bench for apb_mem_bridge with a behavioural single-port memory
//   (write ready same cycle, read ready one cycle after en) and a scoreboard
//   of expected completions.
// -----------------------------------------------------------------------------
module tb_apb_mem_bridge;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int TO    = 16;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
    logic        saw_en;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tie_low = 1'b0;

  int tests = 0;
  int fails = 0;

  exp_t        sb_q[$];
  logic [31:0] model_mem [0:63];

  // memory stand-in state
  logic [31:0] mem_arr [0:63];
  logic        rd_ready_q;
  logic [31:0] rdata_q;

  always #5 clk = ~clk;

  apb_mem_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  apb_mem_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MEM_DEPTH      (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_if  (bus_if.slave)
  );

  // Memory: writes on en&wr edge, read data/ready registered one cycle after en.
  always @(posedge clk) begin
    if (!reset_n) begin
      rd_ready_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      if (bus_if.mem_en && bus_if.mem_wr_rd) begin
        mem_arr[bus_if.mem_addr[5:0]] <= bus_if.mem_wdata;
      end
      rd_ready_q <= bus_if.mem_en & ~bus_if.mem_wr_rd;
      rdata_q    <= mem_arr[bus_if.mem_addr[5:0]];
    end
  end

  assign bus_if.mem_data_ready = tie_low ? 1'b0 : (bus_if.mem_wr_rd | rd_ready_q);
  assign bus_if.mem_rdata      = rdata_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_prdata"},  bus_if.prdata,            32'd0);
    chk({tag, "_pready"},  32'(bus_if.pready),       32'd0);
    chk({tag, "_pslverr"}, 32'(bus_if.pslverr),      32'd0);
    chk({tag, "_mem_en"},  32'(bus_if.mem_en),       32'd0);
    chk({tag, "_wr_rd"},   32'(bus_if.mem_wr_rd),    32'd0);
    chk({tag, "_addr"},    bus_if.mem_addr,          32'd0);
    chk({tag, "_wdata"},   bus_if.mem_wdata,         32'd0);
  endtask

  task automatic idle_cycle();
    tick();
    bus_if.psel    = 1'b0;
    bus_if.penable = 1'b0;
    #1;
    chk("idle_mem_en", 32'(bus_if.mem_en), 32'd0);
    chk("idle_pready", 32'(bus_if.pready), 32'd0);
  endtask

  // One APB transfer; expected completion is pushed before driving it.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    exp_t got;
    logic dec_err;
    logic saw_en;
    logic done;
    int   cyc;
    dec_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH));
    e.saw_en = ~dec_err;
    if (dec_err) begin
      e.err = 1'b1; e.waits = 1;
    end else if (tie_low) begin
      e.err = 1'b1; e.waits = TO;
    end else begin
      e.err = 1'b0; e.waits = wr ? 1 : 2;
    end
    e.rdata = (!e.err && !wr) ? model_mem[addr[7:2]] : 32'd0;
    if (!e.err && wr) model_mem[addr[7:2]] = data;
    sb_q.push_back(e);

    tick();
    bus_if.psel = 1'b1; bus_if.penable = 1'b0;
    bus_if.pwrite = wr; bus_if.paddr = addr; bus_if.pwdata = data;
    #1;
    tick();
    bus_if.penable = 1'b1;
    #1;
    chk("setup_mem_en", 32'(bus_if.mem_en), 32'd0);
    chk("setup_pready", 32'(bus_if.pready), 32'd0);

    cyc = 0; saw_en = 1'b0; done = 1'b0;
    while (!done && cyc < 40) begin
      tick();
      #1;
      cyc++;
      if (bus_if.mem_en) saw_en = 1'b1;
      if (cyc == 1 && !dec_err) begin
        chk("acc_mem_addr", bus_if.mem_addr, addr >> 2);
        chk("acc_wr_rd", 32'(bus_if.mem_wr_rd), 32'(wr));
        if (wr) chk("acc_wdata", bus_if.mem_wdata, data);
      end
      if (bus_if.pready) begin
        got = sb_q.pop_front();
        chk("pslverr", 32'(bus_if.pslverr), 32'(got.err));
        chk("prdata", bus_if.prdata, got.rdata);
        chk("wait_cycles", 32'(cyc), 32'(got.waits));
        chk("saw_mem_en", 32'(saw_en), 32'(got.saw_en));
        done = 1'b1;
      end
    end
    chk("completion_bound", 32'(done), 32'd1);
  endtask

  initial begin
    bus_if.psel = 1'b0; bus_if.penable = 1'b0; bus_if.pwrite = 1'b0;
    bus_if.paddr = 32'd0; bus_if.pwdata = 32'd0;
    reset_n = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    reset_n = 1'b1;

    // write then read back through the memory
    apb_xfer(1'b1, 32'h10, 32'hDEADBEEF); idle_cycle();
    apb_xfer(1'b0, 32'h10, 32'd0);        idle_cycle();

    // decode errors: out of range and misaligned
    apb_xfer(1'b0, 32'h100, 32'd0);       idle_cycle();
    apb_xfer(1'b1, 32'h02, 32'h12345678); idle_cycle();

    // stalled memory -> timeout in ACCESS cycle TO
    tie_low = 1'b1;
    apb_xfer(1'b0, 32'h0, 32'd0);         idle_cycle();
    tie_low = 1'b0;

    // back-to-back with psel held high
    apb_xfer(1'b1, 32'h4, 32'h11111111);
    apb_xfer(1'b0, 32'h4, 32'd0);         idle_cycle();

    // reset during read ACCESS, then enable without a setup phase
    tick();
    bus_if.psel = 1'b1; bus_if.penable = 1'b0; bus_if.pwrite = 1'b0; bus_if.paddr = 32'h10;
    #1;
    tick();
    bus_if.penable = 1'b1;
    #1;
    tick();
    #1;
    chk("rst_acc1_pready", 32'(bus_if.pready), 32'd0);
    chk("rst_acc1_mem_en", 32'(bus_if.mem_en), 32'd1);
    reset_n = 1'b0;
    tick();
    chk_all_zero("midreset");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("noset_mem_en", 32'(bus_if.mem_en), 32'd0);
      chk("noset_pready", 32'(bus_if.pready), 32'd0);
    end
    idle_cycle();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
